// File: rtl/qdiv_arbiter.sv
`timescale 1ns/1ps
// Round-robin front end for a shared fixed-point divider: grants one requester,
// issues its operands, waits for the divider's completion edge or a watchdog expiry, and returns the result.
//
// state | meaning
// IDLE  | arbitrate; a grant latches operands and pulses o_gnt
// ISSUE | operands stable; watchdog cleared; start pulse queued
// WAIT  | start pulse out, then wait for complete rising edge or watchdog
// RESP  | o_result_valid high; pointer advances past the served requester
module qdiv_arbiter #(
    parameter int N_REQ   = 4,
    parameter int W       = 32,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 63
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [N_REQ-1:0]   i_req,
    input  logic [N_REQ*W-1:0] i_dividend,
    input  logic [N_REQ*W-1:0] i_divisor,
    output logic [N_REQ-1:0]   o_gnt,
    output logic               o_busy,
    output logic [W-1:0]       o_result,
    output logic [ID_W-1:0]    o_result_id,
    output logic               o_result_overflow,
    output logic               o_result_timeout,
    output logic               o_result_valid,
    output logic [W-1:0]       o_div_dividend,
    output logic [W-1:0]       o_div_divisor,
    output logic               o_div_start,
    input  logic [W-1:0]       i_div_quotient,
    input  logic               i_div_complete,
    input  logic               i_div_overflow
);

    localparam int WD_W  = $clog2(TIMEOUT + 1);
    localparam int SEL_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              complete_q;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic              busy_q, busy_d;
    logic              start_q, start_d;
    logic [W-1:0]      div_dividend_q, div_dividend_d;
    logic [W-1:0]      div_divisor_q, div_divisor_d;
    logic [W-1:0]      result_q, result_d;
    logic [ID_W-1:0]   result_id_q, result_id_d;
    logic              result_ovf_q, result_ovf_d;
    logic              result_tmo_q, result_tmo_d;
    logic              valid_q, valid_d;

    logic              arb_found;
    logic [ID_W-1:0]   arb_sel;
    logic [W-1:0]      sel_dividend, sel_divisor;
    logic              complete_edge;
    int                arb_idx;

    // Search ptr, ptr+1, ... with explicit wrap so N_REQ need not be a power of two.
    always_comb begin
        arb_found = 1'b0;
        arb_sel   = '0;
        arb_idx   = 0;
        for (int i = 0; i < N_REQ; i++) begin
            arb_idx = int'(ptr_q) + i;
            if (arb_idx >= N_REQ) arb_idx = arb_idx - N_REQ;
            if (!arb_found && i_req[SEL_W'(arb_idx)]) begin
                arb_found = 1'b1;
                arb_sel   = ID_W'(arb_idx);
            end
        end
    end

    always_comb begin
        sel_dividend = '0;
        sel_divisor  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (arb_sel == ID_W'(k)) begin
                sel_dividend = i_dividend[k*W +: W];
                sel_divisor  = i_divisor[k*W +: W];
            end
        end
    end

    // The divider idles with complete high, so only a fresh rise means done.
    assign complete_edge = i_div_complete & ~complete_q;

    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        id_d           = id_q;
        wd_d           = wd_q;
        gnt_d          = '0;
        start_d        = 1'b0;
        valid_d        = 1'b0;
        div_dividend_d = div_dividend_q;
        div_divisor_d  = div_divisor_q;
        result_d       = result_q;
        result_id_d    = result_id_q;
        result_ovf_d   = result_ovf_q;
        result_tmo_d   = result_tmo_q;

        unique case (state_q)
            S_IDLE: begin
                if (arb_found) begin
                    div_dividend_d = sel_dividend;
                    div_divisor_d  = sel_divisor;
                    id_d           = arb_sel;
                    gnt_d          = N_REQ'(1) << arb_sel;
                    state_d        = S_ISSUE;
                end
            end
            S_ISSUE: begin
                start_d = 1'b1;
                wd_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (complete_edge) begin
                    result_d     = i_div_quotient;
                    result_ovf_d = i_div_overflow;
                    result_tmo_d = 1'b0;
                    result_id_d  = id_q;
                    valid_d      = 1'b1;
                    state_d      = S_RESP;
                end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                    wd_d         = wd_q + 1'b1;
                    result_d     = '0;
                    result_ovf_d = 1'b0;
                    result_tmo_d = 1'b1;
                    result_id_d  = id_q;
                    valid_d      = 1'b1;
                    state_d      = S_RESP;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_RESP: begin
                ptr_d   = (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q        <= S_IDLE;
            ptr_q          <= '0;
            id_q           <= '0;
            wd_q           <= '0;
            complete_q     <= 1'b1;
            gnt_q          <= '0;
            busy_q         <= 1'b0;
            start_q        <= 1'b0;
            div_dividend_q <= '0;
            div_divisor_q  <= '0;
            result_q       <= '0;
            result_id_q    <= '0;
            result_ovf_q   <= 1'b0;
            result_tmo_q   <= 1'b0;
            valid_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            id_q           <= id_d;
            wd_q           <= wd_d;
            complete_q     <= i_div_complete;
            gnt_q          <= gnt_d;
            busy_q         <= busy_d;
            start_q        <= start_d;
            div_dividend_q <= div_dividend_d;
            div_divisor_q  <= div_divisor_d;
            result_q       <= result_d;
            result_id_q    <= result_id_d;
            result_ovf_q   <= result_ovf_d;
            result_tmo_q   <= result_tmo_d;
            valid_q        <= valid_d;
        end
    end

    assign o_gnt             = gnt_q;
    assign o_busy            = busy_q;
    assign o_result          = result_q;
    assign o_result_id       = result_id_q;
    assign o_result_overflow = result_ovf_q;
    assign o_result_timeout  = result_tmo_q;
    assign o_result_valid    = valid_q;
    assign o_div_dividend    = div_dividend_q;
    assign o_div_divisor     = div_divisor_q;
    assign o_div_start       = start_q;

endmodule

// File: tb/tb_qdiv_arbiter.sv
`timescale 1ns/1ps
// Bench for qdiv_arbiter: directed requests against a 20-cycle divider model,
// expected grants/results queued by the stimulus and checked by a forked monitor.
module tb_qdiv_arbiter;

    localparam int N_REQ   = 4;
    localparam int W       = 32;
    localparam int ID_W    = 2;
    localparam int TIMEOUT = 63;

    typedef struct {
        logic [ID_W-1:0] id;
        logic [W-1:0]    res;
        logic            ovf;
        logic            tmo;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [N_REQ-1:0]   req = '0;
    logic [N_REQ-1:0]   hold = '0;
    logic [W-1:0]       dvd [N_REQ];
    logic [W-1:0]       dvs [N_REQ];
    logic [N_REQ*W-1:0] dividend_bus, divisor_bus;
    logic [N_REQ-1:0]   o_gnt;
    logic               o_busy, o_result_overflow, o_result_timeout, o_result_valid, o_div_start;
    logic [W-1:0]       o_result, o_div_dividend, o_div_divisor;
    logic [ID_W-1:0]    o_result_id;
    logic [W-1:0]       div_quot = '0;
    logic               div_complete = 1'b1;
    logic               div_ovf = 1'b0;

    // Divider model: quotient = 0x1234 + low byte of dividend; divisor 0 overflows.
    int                 m_cnt = 0;
    logic               m_hang = 1'b0;
    logic [W-1:0]       m_dvd = '0, m_dvs = '0;

    int   checks = 0;
    int   errors = 0;
    int   exp_gnt [$];
    exp_t exp_res [$];
    logic [N_REQ-1:0] gnt_prev = '0;
    logic [W-1:0] gnt_dvd = '0, gnt_dvs = '0;
    logic rise_prev = 1'b0, compl_last = 1'b1;
    int   since_start = 0;
    int   start_cnt = 0;

    assign dividend_bus = {dvd[3], dvd[2], dvd[1], dvd[0]};
    assign divisor_bus  = {dvs[3], dvs[2], dvs[1], dvs[0]};

    always #5 clk = ~clk;

    qdiv_arbiter #(.N_REQ(N_REQ), .W(W), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req),
        .i_dividend(dividend_bus), .i_divisor(divisor_bus),
        .o_gnt(o_gnt), .o_busy(o_busy), .o_result(o_result), .o_result_id(o_result_id),
        .o_result_overflow(o_result_overflow), .o_result_timeout(o_result_timeout),
        .o_result_valid(o_result_valid), .o_div_dividend(o_div_dividend),
        .o_div_divisor(o_div_divisor), .o_div_start(o_div_start),
        .i_div_quotient(div_quot), .i_div_complete(div_complete), .i_div_overflow(div_ovf)
    );

    always @(posedge clk) begin
        if (o_div_start) begin
            m_cnt        <= 20;
            div_complete <= 1'b0;
            m_dvd        <= o_div_dividend;
            m_dvs        <= o_div_divisor;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1 && !m_hang) begin
                div_complete <= 1'b1;
                if (m_dvs == '0) begin
                    div_quot <= 32'hFFFF_FFFF;
                    div_ovf  <= 1'b1;
                end else begin
                    div_quot <= 32'h0000_1234 + {24'h0, m_dvd[7:0]};
                    div_ovf  <= 1'b0;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic push(input int id, input logic [W-1:0] res, input logic ovf, input logic tmo);
        exp_t e;
        e.id = ID_W'(id); e.res = res; e.ovf = ovf; e.tmo = tmo;
        exp_gnt.push_back(id);
        exp_res.push_back(e);
    endtask

    task automatic monitor();
        int   g;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                gnt_prev   = '0;
                rise_prev  = 1'b0;
                compl_last = div_complete;
            end else begin
                if (gnt_prev != '0) begin
                    chk("start after gnt", {63'h0, o_div_start}, 64'h1);
                    chk("issued dividend", {32'h0, o_div_dividend}, {32'h0, gnt_dvd});
                    chk("issued divisor", {32'h0, o_div_divisor}, {32'h0, gnt_dvs});
                end else if (o_div_start) begin
                    chk("start without gnt", {63'h0, o_div_start}, 64'h0);
                end
                if (o_div_start) begin
                    start_cnt++;
                    since_start = 0;
                end else begin
                    since_start++;
                end
                if (o_gnt != '0) begin
                    if (exp_gnt.size() == 0) begin
                        chk("unexpected gnt", {60'h0, o_gnt}, 64'h0);
                    end else begin
                        g = exp_gnt.pop_front();
                        chk("gnt", {60'h0, o_gnt}, 64'(1) << g);
                        gnt_dvd = dvd[g];
                        gnt_dvs = dvs[g];
                    end
                end
                gnt_prev = o_gnt;
                if (rise_prev)
                    chk("valid after complete rise", {63'h0, o_result_valid}, 64'h1);
                if (o_result_valid) begin
                    if (exp_res.size() == 0) begin
                        chk("unexpected valid", {63'h0, o_result_valid}, 64'h0);
                    end else begin
                        e = exp_res.pop_front();
                        chk("result id", {62'h0, o_result_id}, {62'h0, e.id});
                        chk("result", {32'h0, o_result}, {32'h0, e.res});
                        chk("result overflow", {63'h0, o_result_overflow}, {63'h0, e.ovf});
                        chk("result timeout", {63'h0, o_result_timeout}, {63'h0, e.tmo});
                        if (e.tmo)
                            chk("timeout latency", 64'(since_start), 64'(TIMEOUT));
                    end
                end
                rise_prev  = div_complete & ~compl_last;
                compl_last = div_complete;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        for (int k = 0; k < N_REQ; k++)
            if (o_gnt[k] && !hold[k]) req[k] = 1'b0;
    endtask

    task automatic wait_drain(input string nm, input int limit);
        int n = 0;
        while ((exp_gnt.size() != 0 || exp_res.size() != 0 || o_busy) && n < limit) begin
            tick();
            n++;
        end
        checks++;
        if (n >= limit) begin
            errors++;
            $display("FAIL %s: drain bound hit, pending gnt %0d res %0d", nm, exp_gnt.size(), exp_res.size());
            exp_gnt.delete();
            exp_res.delete();
        end
        tick();
        tick();
    endtask

    initial begin
        int n, c;
        for (int k = 0; k < N_REQ; k++) begin
            dvd[k] = 32'h0004_0000 + 32'(k * 'h11);
            dvs[k] = 32'h0002_0000;
        end
        #12;
        chk("reset gnt", {60'h0, o_gnt}, 64'h0);
        chk("reset busy", {63'h0, o_busy}, 64'h0);
        chk("reset start", {63'h0, o_div_start}, 64'h0);
        chk("reset valid", {63'h0, o_result_valid}, 64'h0);
        chk("reset result", {32'h0, o_result}, 64'h0);
        chk("reset div dividend", {32'h0, o_div_dividend}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        fork
            monitor();
        join_none

        // single request, fixed latency
        req[0] = 1'b1;
        push(0, 32'h0000_1234, 1'b0, 1'b0);
        tick();
        chk("s1 gnt at T+1", {60'h0, o_gnt}, 64'h1);
        wait_drain("s1", 200);

        // all four from reset
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        start_cnt = 0;
        req = 4'b1111;
        for (int k = 0; k < N_REQ; k++)
            push(k, 32'h0000_1234 + 32'(k * 'h11), 1'b0, 1'b0);
        wait_drain("s2", 400);
        chk("s2 start count", 64'(start_cnt), 64'd4);

        // 0 and 2 held: alternate
        hold = 4'b0101;
        req  = 4'b0101;
        push(0, 32'h0000_1234, 1'b0, 1'b0);
        push(2, 32'h0000_1256, 1'b0, 1'b0);
        push(0, 32'h0000_1234, 1'b0, 1'b0);
        push(2, 32'h0000_1256, 1'b0, 1'b0);
        n = 0;
        c = 0;
        while (n < 4 && c < 500) begin
            tick();
            if (o_gnt != '0) n++;
            if (n == 4) req = '0;
            c++;
        end
        chk("s3 grants seen", 64'(n), 64'd4);
        req  = '0;
        hold = '0;
        wait_drain("s3", 200);

        // overflow on requester 3, then a clean result for requester 1
        dvs[3] = '0;
        req = 4'b1010;
        push(3, 32'hFFFF_FFFF, 1'b1, 1'b0);
        push(1, 32'h0000_1245, 1'b0, 1'b0);
        wait_drain("s4", 300);
        dvs[3] = 32'h0002_0000;

        // divider hangs: watchdog, then a normal divide
        m_hang = 1'b1;
        req = 4'b0100;
        push(2, 32'h0, 1'b0, 1'b1);
        wait_drain("s5 timeout", 300);
        m_hang = 1'b0;
        req = 4'b0001;
        push(0, 32'h0000_1234, 1'b0, 1'b0);
        wait_drain("s5 recover", 200);

        // reset in WAIT with requester 1 held
        hold = 4'b0010;
        req  = 4'b0010;
        exp_gnt.push_back(1);
        c = 0;
        while (!o_div_start && c < 50) begin
            tick();
            c++;
        end
        chk("s6 start seen", {63'h0, o_div_start}, 64'h1);
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("s6 async busy", {63'h0, o_busy}, 64'h0);
        chk("s6 async result", {32'h0, o_result}, 64'h0);
        chk("s6 async dividend", {32'h0, o_div_dividend}, 64'h0);
        chk("s6 async valid", {63'h0, o_result_valid}, 64'h0);
        hold = '0;
        start_cnt = 0;
        push(1, 32'h0000_1245, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_drain("s6", 200);
        chk("s6 fresh start count", 64'(start_cnt), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
